// File: rtl/maxpool_layer_1_if.sv
// Pixel-stream bundle between conv1, the 2x2 binary max-pool stage and the next conv stage.
// master drives the conv1 pixel stream; slave is the pooling stage.
interface maxpool_layer_1_if #(
  parameter int CH = 8
);
  logic [CH-1:0] conv1_in;
  logic          valid_in_conv1;
  logic [CH-1:0] pool1_out;
  logic          valid_out_pool1;
  logic          frame_done_pool1;

  modport master (
    output conv1_in, valid_in_conv1,
    input  pool1_out, valid_out_pool1, frame_done_pool1
  );

  modport slave (
    input  conv1_in, valid_in_conv1,
    output pool1_out, valid_out_pool1, frame_done_pool1
  );
endinterface

// File: rtl/maxpool_layer_1.sv
// 2x2 stride-2 binary max-pool (per-channel OR) over a raster conv1 feature map.
// Even rows fold horizontal pairs into a half-row buffer; odd rows complete the window and emit.
module maxpool_layer_1 #(
  parameter int IN_WIDTH  = 26,
  parameter int IN_HEIGHT = 26,
  parameter int CH        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  maxpool_layer_1_if.slave   bus
);
  localparam int CW = $clog2(IN_WIDTH);
  localparam int RW = $clog2(IN_HEIGHT);
  localparam int HW = IN_WIDTH / 2;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic [CH-1:0] r_hreg;
  logic [CH-1:0] r_linebuf [HW];
  logic [CH-1:0] r_pool;
  logic          r_valid;
  logic          r_done;
  logic [CW-2:0] w_pair;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_lb_wr;
  logic          w_emit;

  assign w_pair     = r_col[CW-1:1];
  assign w_last_col = (r_col == CW'(IN_WIDTH - 1));
  assign w_last_row = (r_row == RW'(IN_HEIGHT - 1));
  assign w_lb_wr    = bus.valid_in_conv1 & ~r_row[0] & r_col[0];
  assign w_emit     = bus.valid_in_conv1 & r_row[0] & r_col[0];

  // Raster position advance; wraps to (0,0) after the last pixel of a frame.
  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (bus.valid_in_conv1) begin
      if (w_last_col) begin
        w_col_nxt = '0;
        if (w_last_row) begin
          w_row_nxt = '0;
        end else begin
          w_row_nxt = r_row + RW'(1);
        end
      end else begin
        w_col_nxt = r_col + CW'(1);
      end
    end else begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
    end
  end

  // Position, pair register and registered output strobe.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_hreg  <= '0;
      r_pool  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_valid <= w_emit;
      r_done  <= w_emit & w_last_row & w_last_col;
      if (bus.valid_in_conv1 && !r_col[0]) begin
        r_hreg <= bus.conv1_in;
      end
      if (w_emit) begin
        r_pool <= r_linebuf[w_pair] | r_hreg | bus.conv1_in;
      end
    end
  end

  // Half-row buffer: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (!rst_n && w_lb_wr) begin
      r_linebuf[w_pair] <= r_hreg | bus.conv1_in;
    end
  end

  assign bus.pool1_out        = r_pool;
  assign bus.valid_out_pool1  = r_valid;
  assign bus.frame_done_pool1 = r_done;
endmodule

// File: tb/tb_maxpool_layer_1.sv
// Scoreboard bench for maxpool_layer_1: the driver pushes 2x2-OR expectations, a negedge monitor pops them.
module tb_maxpool_layer_1;
  localparam int W  = 26;
  localparam int H  = 26;
  localparam int CH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  maxpool_layer_1_if #(.CH(CH)) bus();

  maxpool_layer_1 #(.IN_WIDTH(W), .IN_HEIGHT(H), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       fd;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc      = 0;
  int         n_chk    = 0;
  int         n_fail   = 0;
  int         n_strobe = 0;
  int         n_done   = 0;
  logic       rst_q    = 1'b1;
  logic [7:0] last_out = 8'h00;
  logic       prev_valid = 1'b0;
  logic [7:0] frame [H][W];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs reflect the most recent rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("reset_pool1_out", 32'(bus.pool1_out), 32'h0);
      chk("reset_valid_out", 32'(bus.valid_out_pool1), 32'h0);
      chk("reset_frame_done", 32'(bus.frame_done_pool1), 32'h0);
    end else if (bus.valid_out_pool1) begin
      n_strobe++;
      if (bus.frame_done_pool1) n_done++;
      chk("no_back_to_back", 32'(prev_valid), 32'h0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("pool1_out", 32'(bus.pool1_out), 32'(e.d));
        chk("frame_done", 32'(bus.frame_done_pool1), 32'(e.fd));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk("hold_pool1_out", 32'(bus.pool1_out), 32'(last_out));
      chk("done_without_valid", 32'(bus.frame_done_pool1), 32'h0);
    end
    last_out   = bus.pool1_out;
    prev_valid = bus.valid_out_pool1;
  end

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.valid_in_conv1 = 1'b0;
    bus.conv1_in       = 8'h00;
    repeat (n - 1) @(posedge clk);
  endtask

  // mode: 0 zeros, 1 ones, 2 single bit at (3,5) ch3, 3 random; gap enables ~40% idle cycles.
  task automatic send_frame(input int mode, input bit gap, input int npix);
    exp_t e;
    int   r;
    int   c;
    for (int rr = 0; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        case (mode)
          0:       frame[rr][cc] = 8'h00;
          1:       frame[rr][cc] = 8'hFF;
          2:       frame[rr][cc] = (rr == 3 && cc == 5) ? 8'h04 : 8'h00;
          default: frame[rr][cc] = 8'($urandom);
        endcase
      end
    end
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / W;
      c = idx % W;
      if (gap) begin
        while ($urandom_range(99) < 40) begin
          @(posedge clk); #1;
          bus.valid_in_conv1 = 1'b0;
          bus.conv1_in       = 8'($urandom);
        end
      end
      @(posedge clk); #1;
      bus.valid_in_conv1 = 1'b1;
      bus.conv1_in       = frame[r][c];
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.d   = frame[r-1][c-1] | frame[r-1][c] | frame[r][c-1] | frame[r][c];
        e.fd  = (r == H - 1) && (c == W - 1);
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    bus.valid_in_conv1 = 1'b0;
    bus.conv1_in       = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    send_frame(0, 1'b0, W * H);
    idle(4);
    send_frame(1, 1'b0, W * H);
    idle(4);
    send_frame(2, 1'b0, W * H);
    idle(4);
    send_frame(3, 1'b1, W * H);
    idle(4);

    // Abort a frame after 300 inputs; the valid pixel during reset must be dropped.
    send_frame(3, 1'b0, 300);
    @(posedge clk); #1;
    rst_n              = 1'b1;
    bus.valid_in_conv1 = 1'b1;
    bus.conv1_in       = 8'hFF;
    @(posedge clk); #1;
    rst_n              = 1'b0;
    bus.valid_in_conv1 = 1'b0;
    idle(3);
    send_frame(3, 1'b0, W * H);
    idle(4);

    send_frame(3, 1'b0, W * H);
    send_frame(3, 1'b0, W * H);
    idle(5);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    chk("total_strobes", 32'(n_strobe), 32'd1255);
    chk("frame_done_pulses", 32'(n_done), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maxpool_layer_1.md
# maxpool_layer_1

Binary 2x2, stride-2 max-pooling stage placed directly after the first convolution layer. It consumes the 8-channel, 1-bit-per-channel raster stream of the 26x26 conv1 feature map. Each channel is reduced to 13x13 by OR-ing every non-overlapping 2x2 window, which is the max for binary data. The result is emitted as a strobed raster stream for the next convolution stage.

## Interface

Parameters:
- IN_WIDTH, 26, conv1 feature-map width in pixels (even values only)
- IN_HEIGHT, 26, conv1 feature-map height in rows (even values only)
- CH, 8, number of channels processed in parallel

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous and active-high: asserted = 1, sampled on rising edge of clk; the _n suffix is kept for port-name compatibility only
- conv1_in  input  CH  one bit per channel; bit k carries conv1 channel k+1
- valid_in_conv1  input  1  conv1_in carries one feature-map pixel this cycle
- pool1_out  output  CH  pooled pixel; bit k is the channel k+1 result
- valid_out_pool1  output  1  pool1_out is valid this cycle (one-cycle strobe per pooled pixel)
- frame_done_pool1  output  1  one-cycle pulse coincident with the last pooled pixel of a frame

## Operation

- Input is strict raster order: row 0 col 0 .. col IN_WIDTH-1, then row 1, and so on. Only cycles with valid_in_conv1=1 advance position. Gaps of any length are allowed and state holds through them.
- Counters:
  - col counts 0..IN_WIDTH-1.
  - row counts 0..IN_HEIGHT-1.
  - Both advance only on a valid input.
  - col wraps to 0 and row increments after col=IN_WIDTH-1.
  - After (IN_HEIGHT-1, IN_WIDTH-1), both wrap to 0, so the next valid input is pixel (0,0) of a new frame.
- Horizontal pair register hreg (CH bits): on a valid input at even col, hreg <= conv1_in.
- Half-row buffer linebuf: IN_WIDTH/2 entries of CH bits.
  - Write occurs on a valid input at even row, odd col: linebuf[col>>1] <= hreg | conv1_in.
  - The buffer needs no reset; every entry is written before it is read.
- Output generation: on a valid input at odd row, odd col, register pool1_out <= linebuf[col>>1] | hreg | conv1_in and set valid_out_pool1=1 for the next cycle.
- Pooled raster index is (row>>1)*(IN_WIDTH/2) + (col>>1). Outputs leave in raster order, IN_WIDTH/2 per odd input row, and (IN_WIDTH/2)*(IN_HEIGHT/2) = 169 per frame at default parameters.
- frame_done_pool1 asserts together with the output produced at input (IN_HEIGHT-1, IN_WIDTH-1).
- pool1_out holds its last value while valid_out_pool1=0.
- Reset, including reset asserted mid-frame:
  - col, row and hreg are cleared to 0.
  - pool1_out = 0, valid_out_pool1 = 0, frame_done_pool1 = 0.
  - Any partial frame is discarded. The first valid input after reset deasserts is treated as pixel (0,0).
- Reset wins over valid_in_conv1 in the same cycle: the input is dropped and no output is produced.

## Timing

- Latency: valid_out_pool1 rises exactly 1 cycle after the clk edge that samples the valid input at (odd row, odd col).
- valid_out_pool1 is never high on two consecutive cycles. At least one valid input (the next even col) separates two outputs.
- No backpressure: the downstream stage must accept every strobe.
- A back-to-back frame is allowed: pixel (0,0) of frame N+1 may arrive on the cycle right after (IN_HEIGHT-1, IN_WIDTH-1) of frame N. The final output of frame N and the first input of frame N+1 must not interfere.
- linebuf is written only on even rows and read only on odd rows, so a read and a write of the same entry never occur in the same cycle.

## Test plan

- All-zero frame, 676 contiguous valids -> exactly 169 valid_out_pool1 strobes, all pool1_out=8'h00; a single frame_done_pool1 pulse on strobe 169.
- All-ones frame -> 169 strobes of 8'hFF. The first strobe comes 1 cycle after the input at (1,1), i.e. input index 27; the strobe is at cycle 28 when the first input is at cycle 0.
- Single 1 at (row 3, col 5) on channel 3 (bit 2), otherwise zero -> only pooled pixel index 1*13+2=15 equals 8'h04; all others are 8'h00.
- Random frame with valid_in_conv1 de-asserted on random cycles (about 40%) -> output sequence is identical to the golden per-channel 2x2 OR model. Each strobe is exactly 1 cycle after its completing input.
- Reset asserted for 1 cycle after 300 inputs, then a full frame -> no strobe during reset. All outputs read 0 after reset. The following frame yields 169 correct outputs with no residue from the aborted frame.
- Two random frames sent back-to-back with no gap -> 338 strobes, both frames match the model, and two frame_done_pool1 pulses occur.
